// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational Alu
//
// Purpose: accepts one operation at a time from two requesters. It holds the
//   winner's operands on the Alu for EXEC_CYCLES cycles, then registers the
//   result and holds it until the winner acknowledges it.
// Parameters: WIDTH (operand/result width, must match the Alu),
//   EXEC_CYCLES (Alu settle cycles before capture, legal range 1..15).
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   req_valid[1:0] / req_ready[1:0] request handshake, bit n = requester n
//   req{0,1}_a/_b/_op/_unsig        requester operands, sampled at accept only
//   resp_valid[1:0] / resp_ack[1:0] response handshake to the owning requester
//   resp_out/_compout/_overflow     registered Alu result
//   alu_a/_b/_op/_unsig             drive the Alu from the latched operands
//   alu_out/_compout/_overflow      Alu results
//   busy                            high whenever not IDLE

module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req0_unsig,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  input  logic             req1_unsig,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ack,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_compout,
  output logic             resp_overflow,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_unsig,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_compout,
  input  logic             alu_overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t           state, state_next;
  logic             rr_ptr;
  logic             owner;
  logic             grant;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic [2:0]       lat_op;
  logic             lat_unsig;

  // rr_ptr only matters under contention; a lone requester always wins.
  always_comb begin
    if (&req_valid) grant = rr_ptr;
    else            grant = req_valid[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready  = grant ? 2'b10 : 2'b01;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) state_next = RESP;
      end
      RESP: begin
        resp_valid = owner ? 2'b10 : 2'b01;
        if (resp_ack[owner]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= 1'b0;
      owner         <= 1'b0;
      cnt           <= 4'd0;
      lat_a         <= '0;
      lat_b         <= '0;
      lat_op        <= 3'd0;
      lat_unsig     <= 1'b0;
      resp_out      <= '0;
      resp_compout  <= 1'b0;
      resp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner     <= grant;
            cnt       <= CNT_LOAD;
            lat_a     <= grant ? req1_a     : req0_a;
            lat_b     <= grant ? req1_b     : req0_b;
            lat_op    <= grant ? req1_op    : req0_op;
            lat_unsig <= grant ? req1_unsig : req0_unsig;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            resp_out      <= alu_out;
            resp_compout  <= alu_compout;
            resp_overflow <= alu_overflow;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // The requester just served yields priority to the other one.
          if (resp_ack[owner]) rr_ptr <= ~owner;
        end
        default: ;
      endcase
    end
  end

  // The Alu sees the latched operands continuously, so its inputs keep the
  // last transaction's values while idle.
  assign alu_a     = lat_a;
  assign alu_b     = lat_b;
  assign alu_op    = lat_op;
  assign alu_unsig = lat_unsig;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a scoreboard and behavioural Alu
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rv, ra;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic [2:0]  r0op, r1op;
  logic        r0u, r1u;

  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_out, alu_a, alu_b, alu_out;
  logic        resp_compout, resp_overflow, alu_unsig, alu_compout, alu_overflow, busy;
  logic [2:0]  alu_op;

  logic [1:0]  rv4, ra4;
  logic [1:0]  req_ready4, resp_valid4;
  logic [31:0] resp_out4, alu_a4, alu_b4, alu_out4;
  logic        resp_compout4, resp_overflow4, alu_unsig4, alu_compout4, alu_overflow4, busy4;
  logic [2:0]  alu_op4;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        id;
    logic [31:0] out;
    logic        comp;
    logic        ovf;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(rst), .req_valid(rv), .req_ready(req_ready),
    .req0_a(r0a), .req0_b(r0b), .req0_op(r0op), .req0_unsig(r0u),
    .req1_a(r1a), .req1_b(r1b), .req1_op(r1op), .req1_unsig(r1u),
    .resp_valid(resp_valid), .resp_ack(ra), .resp_out(resp_out),
    .resp_compout(resp_compout), .resp_overflow(resp_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_unsig(alu_unsig),
    .alu_out(alu_out), .alu_compout(alu_compout), .alu_overflow(alu_overflow),
    .busy(busy)
  );

  alu_arbiter #(.WIDTH(32), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .reset(rst), .req_valid(rv4), .req_ready(req_ready4),
    .req0_a(r0a), .req0_b(r0b), .req0_op(r0op), .req0_unsig(r0u),
    .req1_a(r1a), .req1_b(r1b), .req1_op(r1op), .req1_unsig(r1u),
    .resp_valid(resp_valid4), .resp_ack(ra4), .resp_out(resp_out4),
    .resp_compout(resp_compout4), .resp_overflow(resp_overflow4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_unsig(alu_unsig4),
    .alu_out(alu_out4), .alu_compout(alu_compout4), .alu_overflow(alu_overflow4),
    .busy(busy4)
  );

  // Behavioural Alu: {result, compout, overflow}.
  function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic u);
    logic [32:0] s;
    logic [31:0] o;
    logic        ov, c;
    s  = 33'd0;
    o  = 32'd0;
    ov = 1'b0;
    case (op)
      3'b000: o = a & b;
      3'b001: o = a | b;
      3'b010: begin
        s  = {1'b0, a} + {1'b0, b};
        o  = s[31:0];
        ov = u ? s[32] : ((a[31] == b[31]) && (o[31] != a[31]));
      end
      3'b110: begin
        s  = {1'b0, a} - {1'b0, b};
        o  = s[31:0];
        ov = u ? s[32] : ((a[31] != b[31]) && (o[31] != a[31]));
      end
      default: o = a ^ b;
    endcase
    c = u ? (a < b) : ($signed(a) < $signed(b));
    return {o, c, ov};
  endfunction

  always_comb {alu_out, alu_compout, alu_overflow}    = alu_f(alu_a, alu_b, alu_op, alu_unsig);
  always_comb {alu_out4, alu_compout4, alu_overflow4} = alu_f(alu_a4, alu_b4, alu_op4, alu_unsig4);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result for requester `id` computed from the operands being driven now.
  task automatic push_exp(input logic id);
    exp_t e;
    logic [33:0] r;
    r = id ? alu_f(r1a, r1b, r1op, r1u) : alu_f(r0a, r0b, r0op, r0u);
    e.id   = id;
    e.out  = r[33:2];
    e.comp = r[1];
    e.ovf  = r[0];
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid != 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rv = 2'b00; ra = 2'b00; rv4 = 2'b00; ra4 = 2'b00;
    r0a = 32'd0; r0b = 32'd0; r0op = 3'd0; r0u = 1'b0;
    r1a = 32'd0; r1b = 32'd0; r1op = 3'd0; r1u = 1'b0;
    tick();
    total++;
    if ({req_ready, resp_valid, busy} !== 5'b0)
      $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b, want all 0", req_ready, resp_valid, busy);
    else passed++;
    total++;
    if ({resp_out, resp_compout, resp_overflow, alu_a, alu_b, alu_op, alu_unsig} !== '0)
      $display("FAIL reset_data: got out=%h alu_a=%h alu_b=%h, want all 0", resp_out, alu_a, alu_b);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit   ok;
    exp_t e;
    r0a = 32'h7FFF_FFFF; r0b = 32'h7FFF_FFFF; r0op = 3'b010; r0u = 1'b0;
    rv = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", req_ready);
    else passed++;
    push_exp(1'b0);
    tick();
    rv = 2'b00;
    #1;
    total++;
    if (req_ready !== 2'b00 || busy !== 1'b1 || resp_valid !== 2'b00)
      $display("FAIL single_exec: got ready=%b busy=%b valid=%b want 00/1/00", req_ready, busy, resp_valid);
    else passed++;
    tick();
    total++;
    if (resp_valid !== 2'b01) $display("FAIL single_latency: got valid=%b want 01", resp_valid);
    else passed++;
    wait_resp(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || resp_out !== e.out || resp_overflow !== e.ovf || resp_compout !== e.comp || resp_out !== 32'hFFFF_FFFE)
      $display("FAIL single_result: got out=%h ovf=%b comp=%b want out=%h ovf=%b comp=%b",
               resp_out, resp_overflow, resp_compout, e.out, e.ovf, e.comp);
    else passed++;
    ra = 2'b01;
    tick();
    ra = 2'b00;
    #1;
    total++;
    if (busy !== 1'b0 || resp_valid !== 2'b00)
      $display("FAIL single_done: got busy=%b valid=%b want 0/00", busy, resp_valid);
    else passed++;
  endtask

  task automatic test_fairness();
    bit   ok;
    exp_t e;
    logic expg;
    pulse_reset();
    r0a = 32'd5;  r0b = 32'd3;  r0op = 3'b010; r0u = 1'b0;
    r1a = 32'd10; r1b = 32'd20; r1op = 3'b010; r1u = 1'b0;
    rv = 2'b11;
    #1;
    for (int t = 0; t < 6; t++) begin
      expg = t[0];
      total++;
      if (req_ready !== (expg ? 2'b10 : 2'b01))
        $display("FAIL fair_grant%0d: got %b want %b", t, req_ready, expg ? 2'b10 : 2'b01);
      else passed++;
      push_exp(expg);
      tick();
      wait_resp(ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || resp_valid !== (e.id ? 2'b10 : 2'b01) || resp_out !== e.out ||
          resp_out !== (e.id ? 32'd30 : 32'd8))
        $display("FAIL fair_result%0d: got valid=%b out=%0d want id=%0d out=%0d", t, resp_valid, resp_out, e.id, e.out);
      else passed++;
      ra = resp_valid;
      #1;
      total++;
      if (req_ready !== 2'b00) $display("FAIL fair_ack_cycle%0d: got ready=%b want 00", t, req_ready);
      else passed++;
      tick();
      ra = 2'b00;
      #1;
    end
    rv = 2'b00;
    #1;
  endtask

  task automatic test_ack_holdoff();
    bit          ok;
    exp_t        e;
    logic [31:0] held;
    pulse_reset();
    r0a = 32'h1234_0000; r0b = 32'h0000_5678; r0op = 3'b001; r0u = 1'b1;
    r1a = 32'd40; r1b = 32'd2; r1op = 3'b110; r1u = 1'b1;
    rv = 2'b01;
    #1;
    push_exp(1'b0);
    tick();
    rv = 2'b10;
    wait_resp(ok);
    e = exp_q.pop_front();
    held = resp_out;
    total++;
    if (!ok || held !== e.out || held !== 32'h1234_5678)
      $display("FAIL hold_result: got %h want %h", held, e.out);
    else passed++;
    ra = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (resp_valid !== 2'b01 || resp_out !== held || req_ready !== 2'b00)
        $display("FAIL hold_cycle%0d: got valid=%b out=%h ready=%b want 01/%h/00", i, resp_valid, resp_out, req_ready, held);
      else passed++;
      tick();
    end
    ra = 2'b01;
    tick();
    ra = 2'b00;
    #1;
    total++;
    if (req_ready !== 2'b10) $display("FAIL hold_next_grant: got %b want 10", req_ready);
    else passed++;
    push_exp(1'b1);
    tick();
    rv = 2'b00;
    wait_resp(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || resp_valid !== 2'b10 || resp_out !== e.out || resp_out !== 32'd38 || resp_compout !== e.comp)
      $display("FAIL hold_r1_result: got valid=%b out=%0d want 10/%0d", resp_valid, resp_out, e.out);
    else passed++;
    ra = 2'b10;
    tick();
    ra = 2'b00;
    #1;
  endtask

  task automatic test_back_to_back();
    bit   ok;
    exp_t e;
    pulse_reset();
    r0a = 32'hFFFF_FFFF; r0b = 32'd1; r0op = 3'b010; r0u = 1'b1;
    r1a = 32'h8000_0000; r1b = 32'd1; r1op = 3'b110; r1u = 1'b0;
    rv = 2'b01;
    #1;
    push_exp(1'b0);
    tick();
    rv = 2'b10;
    wait_resp(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || resp_out !== e.out || resp_overflow !== e.ovf || resp_overflow !== 1'b1)
      $display("FAIL b2b_r0: got out=%h ovf=%b want %h/%b", resp_out, resp_overflow, e.out, e.ovf);
    else passed++;
    ra = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b00) $display("FAIL b2b_same_cycle: got %b want 00", req_ready);
    else passed++;
    tick();
    ra = 2'b00;
    #1;
    total++;
    if (req_ready !== 2'b10) $display("FAIL b2b_next_cycle: got %b want 10", req_ready);
    else passed++;
    push_exp(1'b1);
    tick();
    rv = 2'b00;
    wait_resp(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || resp_valid !== 2'b10 || resp_out !== e.out || resp_overflow !== e.ovf || resp_compout !== e.comp)
      $display("FAIL b2b_r1: got out=%h ovf=%b comp=%b want %h/%b/%b", resp_out, resp_overflow, resp_compout, e.out, e.ovf, e.comp);
    else passed++;
    ra = 2'b10;
    tick();
    ra = 2'b00;
    #1;
  endtask

  task automatic test_exec_cycles();
    logic [1:0] want;
    r0a = 32'd100; r0b = 32'd23; r0op = 3'b010; r0u = 1'b0;
    rv4 = 2'b01;
    #1;
    total++;
    if (req_ready4 !== 2'b01) $display("FAIL exec4_ready: got %b want 01", req_ready4);
    else passed++;
    tick();
    rv4 = 2'b00;
    r0a = 32'hDEAD_BEEF; r0b = 32'h0BAD_F00D; r0op = 3'b000; r0u = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      want = (k == 4) ? 2'b01 : 2'b00;
      total++;
      if (resp_valid4 !== want || busy4 !== 1'b1)
        $display("FAIL exec4_edge%0d: got valid=%b busy=%b want %b/1", k, resp_valid4, busy4, want);
      else passed++;
    end
    total++;
    if (resp_out4 !== 32'd123 || resp_overflow4 !== 1'b0 || resp_compout4 !== 1'b0 || alu_a4 !== 32'd100 || alu_b4 !== 32'd23)
      $display("FAIL exec4_result: got out=%0d alu_a=%0d alu_b=%0d want 123/100/23", resp_out4, alu_a4, alu_b4);
    else passed++;
    ra4 = 2'b01;
    tick();
    ra4 = 2'b00;
    #1;
  endtask

  task automatic test_reset_mid();
    bit   ok;
    exp_t e;
    pulse_reset();
    // One completed requester-0 transaction moves rr_ptr to 1.
    r0a = 32'd1; r0b = 32'd2; r0op = 3'b010; r0u = 1'b0;
    r1a = 32'd7; r1b = 32'd9; r1op = 3'b110; r1u = 1'b0;
    rv = 2'b01;
    tick();
    rv = 2'b00;
    wait_resp(ok);
    ra = 2'b01;
    tick();
    ra = 2'b00;
    rv = 2'b01;
    tick();
    rv = 2'b00;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, req_ready, resp_valid} !== 5'b0 || resp_out !== 32'd0 || alu_a !== 32'd0 || alu_b !== 32'd0)
      $display("FAIL rst_exec: got busy=%b valid=%b out=%h alu_a=%h want all 0", busy, resp_valid, resp_out, alu_a);
    else passed++;
    rst = 1'b0;
    rv = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL rst_rr_ptr: got %b want 01", req_ready);
    else passed++;
    rv = 2'b00;
    tick();
    tick();
    total++;
    if (resp_valid !== 2'b00 || busy !== 1'b0)
      $display("FAIL rst_no_resp: got valid=%b busy=%b want 00/0", resp_valid, busy);
    else passed++;
    rv = 2'b10;
    tick();
    rv = 2'b00;
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (resp_valid !== 2'b00 || resp_out !== 32'd0 || resp_compout !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_resp: got valid=%b out=%h comp=%b busy=%b want 0", resp_valid, resp_out, resp_compout, busy);
    else passed++;
    rst = 1'b0;
    rv = 2'b10;
    #1;
    total++;
    if (req_ready !== 2'b10) $display("FAIL rst_first_idle: got %b want 10", req_ready);
    else passed++;
    push_exp(1'b1);
    tick();
    rv = 2'b00;
    wait_resp(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || resp_valid !== 2'b10 || resp_out !== e.out || resp_out !== 32'hFFFF_FFFE || resp_compout !== e.comp)
      $display("FAIL rst_r1_result: got valid=%b out=%h want 10/%h", resp_valid, resp_out, e.out);
    else passed++;
    ra = 2'b10;
    tick();
    ra = 2'b00;
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_ack_holdoff();
    test_back_to_back();
    test_exec_cycles();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
